fpu_result_collector: RTL and testbench

Issue-gating and result-capture stage placed around the 6-stage pipelined FPU core. It accepts operation requests with a valid/ready handshake and drives the FPU `start` strobe. It tracks every issued operation through a shadow delay line matched to the FPU latency. It captures `Y`/`error`/`overflow` exactly when each result lands and queues them in a FIFO with a valid/ready output. Credit accounting guarantees that no FPU result is ever dropped, even under sustained downstream backpressure.

---
 rtl/fpu_result_collector.sv | 125 ++++++++++++
 tb/tb_fpu_result_collector.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_collector.sv
// Issue gate and in-order result queue wrapped around a fixed-latency pipelined FPU.
// Credits (queued + in flight) bound issue so every FPU result always has a FIFO slot.
module fpu_result_collector #(
    parameter int DEPTH   = 8,
    parameter int LATENCY = 6,
    parameter int TAG_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [1:0]               issue_sel,
    input  logic [TAG_W-1:0]         issue_tag,
    output logic                     fpu_start,
    output logic [1:0]               fpu_sel,
    input  logic [31:0]              fpu_y,
    input  logic                     fpu_error,
    input  logic                     fpu_overflow,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_y,
    output logic                     res_error,
    output logic                     res_overflow,
    output logic [1:0]               res_sel,
    output logic [TAG_W-1:0]         res_tag,
    output logic [$clog2(DEPTH):0]   inflight
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [LATENCY:0]   pv_q;
    logic [1:0]         ps_q [LATENCY+1];
    logic [TAG_W-1:0]   pt_q [LATENCY+1];

    logic [CW-1:0]      inflight_q, inflight_d;
    logic [CW-1:0]      count_q, count_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;

    logic [31:0]        my_q  [DEPTH];
    logic [DEPTH-1:0]   err_q;
    logic [DEPTH-1:0]   ovf_q;
    logic [1:0]         sel_q [DEPTH];
    logic [TAG_W-1:0]   tag_q [DEPTH];

    logic               retire;
    logic               pop;
    logic [CW:0]        used;

    // Credits come from registered state only, so a pop frees its slot one cycle later.
    assign used        = {1'b0, count_q} + {1'b0, inflight_q};
    assign issue_ready = (used < (CW+1)'(DEPTH));
    assign fpu_start   = issue_valid & issue_ready;
    assign fpu_sel     = issue_sel;
    assign retire      = pv_q[LATENCY];
    assign res_valid   = (count_q != '0);
    assign pop         = res_valid & res_ready;
    assign inflight    = inflight_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pv_q <= '0;
            for (int i = 0; i <= LATENCY; i++) begin
                ps_q[i] <= '0;
                pt_q[i] <= '0;
            end
        end else begin
            pv_q    <= {pv_q[LATENCY-1:0], fpu_start};
            ps_q[0] <= issue_sel;
            pt_q[0] <= issue_tag;
            for (int i = 1; i <= LATENCY; i++) begin
                ps_q[i] <= ps_q[i-1];
                pt_q[i] <= pt_q[i-1];
            end
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (fpu_start) inflight_d = inflight_d + CW'(1);
        if (retire) begin
            inflight_d = inflight_d - CW'(1);
            count_d    = count_d + CW'(1);
            wr_ptr_d   = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            count_d  = count_d - CW'(1);
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (retire) begin
            my_q[wr_ptr_q]  <= fpu_y;
            err_q[wr_ptr_q] <= fpu_error;
            ovf_q[wr_ptr_q] <= fpu_overflow;
            sel_q[wr_ptr_q] <= ps_q[LATENCY];
            tag_q[wr_ptr_q] <= pt_q[LATENCY];
        end
    end

    assign res_y        = res_valid ? my_q[rd_ptr_q]  : '0;
    assign res_error    = res_valid ? err_q[rd_ptr_q] : 1'b0;
    assign res_overflow = res_valid ? ovf_q[rd_ptr_q] : 1'b0;
    assign res_sel      = res_valid ? sel_q[rd_ptr_q] : '0;
    assign res_tag      = res_valid ? tag_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_fpu_result_collector.sv
// Bench for fpu_result_collector: a latency-6 FPU stand-in plus an issue-order
// queue model keyed on capture edge numbers.
module tb_fpu_result_collector;
    localparam int DEPTH = 8;
    localparam int LAT   = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_ready, fpu_start;
    logic [1:0]  issue_sel, fpu_sel, res_sel;
    logic [3:0]  issue_tag, res_tag;
    logic [31:0] fpu_y, res_y;
    logic        fpu_error, fpu_overflow;
    logic        res_valid, res_ready, res_error, res_overflow;
    logic [3:0]  inflight;

    fpu_result_collector #(.DEPTH(DEPTH), .LATENCY(LAT), .TAG_W(4)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_sel(issue_sel), .issue_tag(issue_tag),
        .fpu_start(fpu_start), .fpu_sel(fpu_sel),
        .fpu_y(fpu_y), .fpu_error(fpu_error), .fpu_overflow(fpu_overflow),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_error(res_error), .res_overflow(res_overflow),
        .res_sel(res_sel), .res_tag(res_tag), .inflight(inflight)
    );

    always #5 clk = ~clk;

    // FPU stand-in: result chosen at issue time appears on fpu_y LAT edges later.
    logic [31:0] cur_y;
    logic        cur_e, cur_o;
    logic        fs_v [LAT];
    logic [33:0] fs_d [LAT];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) begin
                fs_v[i] <= 1'b0;
                fs_d[i] <= '0;
            end
            fpu_y        <= '0;
            fpu_error    <= 1'b0;
            fpu_overflow <= 1'b0;
        end else begin
            fs_v[0] <= fpu_start;
            fs_d[0] <= {cur_e, cur_o, cur_y};
            for (int i = 1; i < LAT; i++) begin
                fs_v[i] <= fs_v[i-1];
                fs_d[i] <= fs_d[i-1];
            end
            if (fs_v[LAT-1]) begin
                fpu_y        <= fs_d[LAT-1][31:0];
                fpu_overflow <= fs_d[LAT-1][32];
                fpu_error    <= fs_d[LAT-1][33];
            end
        end
    end

    logic retire_full_seen = 1'b0;
    always @(posedge clk) begin
        if (reset && dut.retire && !dut.pop && dut.count_q == 4'd8)
            retire_full_seen <= 1'b1;
    end

    typedef struct {
        logic [31:0] y;
        logic        e;
        logic        o;
        logic [1:0]  s;
        logic [3:0]  t;
        int          cap;
    } op_t;

    op_t  inq[$];
    op_t  pend;
    int   now = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic do_issue, do_pop;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, now);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk32(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Issue-to-capture is LAT+1 edges; used credits are simply issued-but-not-popped.
    task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] t,
                         input logic r, input logic [31:0] y, input logic e, input logic o);
        int  n_if;
        logic exp_ready, exp_rv;
        issue_valid = v; issue_sel = s; issue_tag = t; res_ready = r;
        cur_y = y; cur_e = e; cur_o = o;
        #1;
        n_if = 0;
        foreach (inq[i]) if (inq[i].cap > now) n_if++;
        exp_ready = (inq.size() < DEPTH);
        exp_rv    = (inq.size() > 0) && (inq[0].cap <= now);
        chk1("issue_ready", issue_ready, exp_ready);
        chk1("fpu_start", fpu_start, v & exp_ready);
        chk32("fpu_sel", 32'(fpu_sel), 32'(s));
        chk32("inflight", 32'(inflight), 32'(n_if));
        chk1("res_valid", res_valid, exp_rv);
        if (exp_rv) begin
            chk32("res_y", res_y, inq[0].y);
            chk1("res_error", res_error, inq[0].e);
            chk1("res_overflow", res_overflow, inq[0].o);
            chk32("res_sel", 32'(res_sel), 32'(inq[0].s));
            chk32("res_tag", 32'(res_tag), 32'(inq[0].t));
        end
        do_issue = v & exp_ready;
        do_pop   = exp_rv & r;
        pend.y = y; pend.e = e; pend.o = o; pend.s = s; pend.t = t; pend.cap = 0;
    endtask

    task automatic step();
        @(posedge clk);
        now++;
        if (do_pop) void'(inq.pop_front());
        if (do_issue) begin
            pend.cap = now + LAT + 1;
            inq.push_back(pend);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 2'b00, 4'h0, r, 32'h0, 1'b0, 1'b0);
            step();
        end
    endtask

    typedef struct {
        logic       v;
        logic [1:0] s;
        logic [3:0] t;
        logic       r;
        logic       exp_start;
    } vec_t;

    vec_t vecs [6];
    int   ntag;

    initial begin
        vecs[0] = '{1'b0, 2'b00, 4'd0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 2'b00, 4'd1, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 2'b10, 4'd0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 2'b01, 4'd2, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 2'b11, 4'd3, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 2'b11, 4'd0, 1'b0, 1'b0};

        reset = 1'b0; issue_valid = 1'b0; issue_sel = 2'b00; issue_tag = 4'h0;
        res_ready = 1'b0; cur_y = '0; cur_e = 1'b0; cur_o = 1'b0;
        do_issue = 1'b0; do_pop = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk1("rst_res_valid", res_valid, 1'b0);
        chk32("rst_res_y", res_y, 32'h0);
        chk1("rst_res_error", res_error, 1'b0);
        chk1("rst_res_overflow", res_overflow, 1'b0);
        chk32("rst_res_sel", 32'(res_sel), 32'h0);
        chk32("rst_res_tag", 32'(res_tag), 32'h0);
        chk32("rst_inflight", 32'(inflight), 32'h0);
        chk1("rst_issue_ready", issue_ready, 1'b1);
        chk1("rst_fpu_start", fpu_start, 1'b0);
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].s, vecs[i].t, vecs[i].r, 32'h1000 + i, 1'b0, 1'b0);
            chk1("tbl_start", fpu_start, vecs[i].exp_start);
            step();
        end
        idle(12, 1'b1);

        // 1.0 + 2.0 must surface exactly seven edges after issue
        drive(1'b1, 2'b00, 4'd3, 1'b1, 32'h4040_0000, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 8; i++) begin
            chk1("add_latency", res_valid, (i == 7));
            if (i == 7) begin
                chk32("add_y", res_y, 32'h4040_0000);
                chk32("add_tag", 32'(res_tag), 32'd3);
            end
            idle(1, 1'b1);
        end

        // fill under backpressure, valid held; tag advances only on accepted issue
        ntag = 0;
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 2'b10, 4'(ntag), 1'b0, 32'h4100_0000 + ntag, 1'b0, 1'b0);
            step();
            if (do_issue) ntag++;
        end
        chk32("fill_issued", 32'(ntag), 32'd8);
        chk1("fill_ready_low", issue_ready, 1'b0);
        chk32("fill_inflight", 32'(inflight), 32'd0);
        drive(1'b1, 2'b10, 4'(ntag), 1'b1, 32'h4100_0000 + ntag, 1'b0, 1'b0);
        chk1("full_pop_ready", issue_ready, 1'b0);
        step();
        drive(1'b1, 2'b10, 4'(ntag), 1'b0, 32'h4100_0000 + ntag, 1'b0, 1'b0);
        chk1("after_pop_ready", issue_ready, 1'b1);
        step();
        idle(8, 1'b0);
        chk1("refull_ready_low", issue_ready, 1'b0);
        chk32("refull_inflight", 32'(inflight), 32'd0);
        idle(12, 1'b1);

        // divide by zero sandwiched between adds
        drive(1'b1, 2'b00, 4'd4, 1'b1, 32'h4040_0000, 1'b0, 1'b0); step();
        drive(1'b1, 2'b11, 4'd5, 1'b1, 32'h7F80_0000, 1'b1, 1'b1); step();
        drive(1'b1, 2'b00, 4'd6, 1'b1, 32'h40A0_0000, 1'b0, 1'b0); step();
        idle(12, 1'b1);

        // streaming: 20 ops; credit round trip is 8 edges, so ready may briefly dip
        ntag = 0;
        for (int i = 0; i < 60 && ntag < 20; i++) begin
            drive(1'b1, 2'(ntag), 4'(ntag), 1'b1, 32'h3F80_0000 ^ ntag, 1'b0, 1'b0);
            step();
            if (do_issue) ntag++;
        end
        chk32("stream_issued", 32'(ntag), 32'd20);
        idle(12, 1'b1);

        // reset mid-flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b01, 4'(i), 1'b1, 32'hABC0_0000 + i, 1'b0, 1'b0);
            step();
        end
        idle(3, 1'b1);
        reset = 1'b0;
        issue_valid = 1'b0;
        #1;
        chk1("mid_rst_res_valid", res_valid, 1'b0);
        chk32("mid_rst_inflight", 32'(inflight), 32'd0);
        inq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk1("post_rst_ready", issue_ready, 1'b1);
        chk1("post_rst_res_valid", res_valid, 1'b0);
        @(negedge clk);
        idle(10, 1'b1);

        // randomized traffic with bursts of backpressure
        for (int i = 0; i < 500; i++) begin
            logic v, r;
            v = ($urandom_range(0, 3) != 0);
            r = ((i % 120) < 40) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
            drive(v, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), r,
                  $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
        end
        idle(20, 1'b1);

        chk1("no_retire_into_full", retire_full_seen, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
